// File: rtl/elastic_pkg.sv
// elastic_pkg: shared widths, opcode encoding and handshake bundle for the
// CGRA processing-element elastic stage.
// Optional feature macro: ELASTIC_ALU_DIV_EN (enables opcode 13 as unsigned DIV).
package elastic_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int ADDRESS_WIDTH        = 32;
  localparam int OPERATION_BIT_LENGTH = 4;

  typedef enum logic [OPERATION_BIT_LENGTH-1:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_SHL   = 4'd4,
    OP_SHR   = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_XOR   = 4'd8,
    OP_LOAD  = 4'd9,
    OP_STORE = 4'd10,
    OP_CONST = 4'd11,
    OP_ROUTE = 4'd12,
    OP_DIV   = 4'd13
  } opcode_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  stop;
  } ElasticWire;

  // True for opcodes that leave a result token in the output register.
  function automatic logic op_produces_token(input logic [OPERATION_BIT_LENGTH-1:0] op);
    logic res;
    res = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_SHL, OP_SHR,
      OP_AND, OP_OR, OP_XOR, OP_LOAD, OP_CONST, OP_ROUTE: res = 1'b1;
`ifdef ELASTIC_ALU_DIV_EN
      OP_DIV: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/elastic_alu_datapath.sv
// elastic_alu_datapath: purely combinational result function of the opcode,
// both operands, the context constant and same-cycle memory read data.
// Optional feature macro: ELASTIC_ALU_DIV_EN (adds an unsigned divider on opcode 13).
module elastic_alu_datapath #(
  parameter int DATA_WIDTH           = elastic_pkg::DATA_WIDTH,
  parameter int OPERATION_BIT_LENGTH = elastic_pkg::OPERATION_BIT_LENGTH
) (
  input  logic [OPERATION_BIT_LENGTH-1:0] op_i,
  input  logic [DATA_WIDTH-1:0]           a_i,
  input  logic [DATA_WIDTH-1:0]           b_i,
  input  logic [DATA_WIDTH-1:0]           const_i,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
  output logic [DATA_WIDTH-1:0]           result_o
);
  import elastic_pkg::*;

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b_i[SHAMT_W-1:0];

  // Select the result for the current opcode; non-producing codes yield zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:   result_o = a_i + b_i;
      OP_SUB:   result_o = a_i - b_i;
      OP_MUL:   result_o = a_i * b_i;
      OP_SHL:   result_o = a_i << shamt;
      OP_SHR:   result_o = a_i >> shamt;
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_LOAD:  result_o = mem_rdata_i;
      OP_CONST: result_o = const_i;
      OP_ROUTE: result_o = a_i;
`ifdef ELASTIC_ALU_DIV_EN
      OP_DIV:   result_o = (b_i == '0) ? '1 : (a_i / b_i);
`endif
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/elastic_alu.sv
// elastic_alu: elastic (SELF) ALU/memory stage of a CGRA PE. Joins an operand
// pair, computes under the context opcode and holds one registered result token.
// Optional feature macro: ELASTIC_ALU_DIV_EN (opcode 13 becomes unsigned DIV).
module elastic_alu #(
  parameter int DATA_WIDTH           = elastic_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH        = elastic_pkg::ADDRESS_WIDTH,
  parameter int OPERATION_BIT_LENGTH = elastic_pkg::OPERATION_BIT_LENGTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [DATA_WIDTH-1:0]           input_data_1,
  input  logic [DATA_WIDTH-1:0]           input_data_2,
  input  logic [OPERATION_BIT_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]           const_data,
  input  logic [1:0]                      valid_input,
  output logic [1:0]                      stop_input,
  output logic [DATA_WIDTH-1:0]           output_data,
  output logic                            valid_output,
  input  logic                            stop_output,
  output logic [ADDRESS_WIDTH-1:0]        memory_read_address,
  input  logic [DATA_WIDTH-1:0]           memory_read_data,
  output logic [ADDRESS_WIDTH-1:0]        memory_write_address,
  output logic                            memory_write,
  output logic [DATA_WIDTH-1:0]           memory_write_data,
  output logic                            switch_context
);
  import elastic_pkg::*;

  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  valid_d, valid_q;
  logic                  stall;
  logic                  is_const;
  logic                  fire;

  elastic_alu_datapath #(
    .DATA_WIDTH           (DATA_WIDTH),
    .OPERATION_BIT_LENGTH (OPERATION_BIT_LENGTH)
  ) u_datapath (
    .op_i        (op),
    .a_i         (input_data_1),
    .b_i         (input_data_2),
    .const_i     (const_data),
    .mem_rdata_i (memory_read_data),
    .result_o    (result)
  );

  // Handshake: a held token that cannot leave stalls the stage. CONST needs no
  // operands, so it never consumes them. Gating with reset_n keeps the context
  // pulse and store strobe quiet while the PE is held in reset.
  always_comb begin
    stall      = valid_q && stop_output;
    is_const   = (op == OP_CONST);
    stop_input = {2{stall || is_const}};
    if (is_const) fire = reset_n && !stall;
    else          fire = reset_n && valid_input[0] && valid_input[1] && !stall;
  end

  assign switch_context       = fire;
  assign memory_read_address  = input_data_1[ADDRESS_WIDTH-1:0];
  assign memory_write_address = input_data_1[ADDRESS_WIDTH-1:0];
  assign memory_write_data    = input_data_2;
  assign memory_write         = fire && (op == OP_STORE);

  // Next token state: capture on a producing fire (may overlap with the old
  // token leaving), otherwise drop valid once the token is accepted.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (fire && op_produces_token(op)) begin
      data_d  = result;
      valid_d = 1'b1;
    end else if (valid_q && !stop_output) begin
      valid_d = 1'b0;
    end
  end

  // Output token register; reset discards any in-flight token.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign output_data  = data_q;
  assign valid_output = valid_q;

endmodule

// File: tb/tb_elastic_alu.sv
// tb_elastic_alu: directed plus randomized bench for elastic_alu with a
// token-level reference model. Define ELASTIC_ALU_DIV_EN to cover DIV.
module tb_elastic_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] input_data_1, input_data_2, const_data;
  logic [3:0]  op;
  logic [1:0]  valid_input;
  logic [1:0]  stop_input;
  logic [31:0] output_data;
  logic        valid_output;
  logic        stop_output;
  logic [31:0] memory_read_address, memory_read_data;
  logic [31:0] memory_write_address, memory_write_data;
  logic        memory_write;
  logic        switch_context;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the token the stage should be holding.
  bit          m_valid;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  elastic_alu dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .input_data_1         (input_data_1),
    .input_data_2         (input_data_2),
    .op                   (op),
    .const_data           (const_data),
    .valid_input          (valid_input),
    .stop_input           (stop_input),
    .output_data          (output_data),
    .valid_output         (valid_output),
    .stop_output          (stop_output),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .memory_write_address (memory_write_address),
    .memory_write         (memory_write),
    .memory_write_data    (memory_write_data),
    .switch_context       (switch_context)
  );

  // Bench memory: a fixed word at 0x40, an address-derived pattern elsewhere.
  function automatic logic [31:0] ref_mem(input logic [31:0] addr);
    if (addr == 32'h40) return 32'hDEAD;
    return (~addr) + 32'h1234;
  endfunction

  assign memory_read_data = ref_mem(memory_read_address);

  function automatic bit ref_produces(input int opc);
    bit div_on;
`ifdef ELASTIC_ALU_DIV_EN
    div_on = 1'b1;
`else
    div_on = 1'b0;
`endif
    return (opc >= 1 && opc <= 9) || opc == 11 || opc == 12 || (div_on && opc == 13);
  endfunction

  function automatic logic [31:0] ref_result(input int opc, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
    logic [63:0] prod;
    int          sh;
    sh   = int'(b % 32);
    prod = {32'd0, a} * {32'd0, b};
    case (opc)
      1:  return a + b;
      2:  return a - b;
      3:  return prod[31:0];
      4:  return a << sh;
      5:  return a >> sh;
      6:  return a & b;
      7:  return a | b;
      8:  return a ^ b;
      9:  return ref_mem(a);
      11: return c;
      12: return a;
      13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int opc, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] v, input bit stp, input logic [31:0] c);
    op           = 4'(opc);
    input_data_1 = a;
    input_data_2 = b;
    valid_input  = v;
    stop_output  = stp;
    const_data   = c;
  endtask

  // One clock: inputs were driven just after the previous posedge. Check the
  // combinational handshake mid-cycle, advance the model, check the token.
  task automatic cycle();
    bit stall, fire, isc;
    int opc;
    #4;
    opc   = int'(op);
    isc   = (opc == 11);
    stall = m_valid && stop_output;
    fire  = isc ? !stall : (valid_input == 2'b11 && !stall);
    check("stop_input", 32'(stop_input), (stall || isc) ? 32'd3 : 32'd0);
    check("switch_context", 32'(switch_context), 32'(fire));
    check("memory_write", 32'(memory_write), 32'(fire && opc == 10));
    check("rd_addr", memory_read_address, input_data_1);
    if (fire && opc == 10) begin
      check("wr_addr", memory_write_address, input_data_1);
      check("wr_data", memory_write_data, input_data_2);
    end
    if (fire && ref_produces(opc)) begin
      m_data  = ref_result(opc, input_data_1, input_data_2, const_data);
      m_valid = 1'b1;
    end else if (m_valid && !stop_output) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("valid_output", 32'(valid_output), 32'(m_valid));
    check("output_data", output_data, m_data);
  endtask

  initial begin
    int opc;
    logic [31:0] a, b;
    reset_n = 1'b0;
    m_valid = 1'b0;
    m_data  = 32'd0;
    drive(1, 32'd1, 32'd2, 2'b11, 1'b0, 32'd0);
    #2;
    check("rst_valid", 32'(valid_output), 32'd0);
    check("rst_data", output_data, 32'd0);
    check("rst_switch", 32'(switch_context), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    drive(0, 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);
    @(posedge clk);
    #1;

    // ADD, then idle so the context pulse is seen only in the firing cycle
    drive(1, 32'd5, 32'd7, 2'b11, 1'b0, 32'd0); cycle();
    check("add_5_7", output_data, 32'd12);
    check("add_valid", 32'(valid_output), 32'd1);
    drive(0, 32'd0, 32'd0, 2'b00, 1'b0, 32'd0); cycle();

    // SUB then three stalled cycles, then release with a pair waiting
    drive(2, 32'd10, 32'd3, 2'b11, 1'b0, 32'd0); cycle();
    check("sub_10_3", output_data, 32'd7);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'd1, 32'd1, 2'b11, 1'b1, 32'd0); cycle();
      check("stall_hold", output_data, 32'd7);
    end
    drive(1, 32'd1, 32'd1, 2'b11, 1'b0, 32'd0); cycle();
    check("release_next", output_data, 32'd2);

    // LOAD and STORE
    drive(9, 32'h40, 32'd0, 2'b11, 1'b0, 32'd0); cycle();
    check("load_dead", output_data, 32'hDEAD);
    drive(10, 32'h44, 32'd9, 2'b11, 1'b0, 32'd0); cycle();
    check("store_no_token", 32'(valid_output), 32'd0);

    // CONST without operands, then NOP consuming a pair
    for (int i = 0; i < 3; i++) begin
      drive(11, 32'd0, 32'd0, 2'b00, 1'b0, 32'd42); cycle();
      check("const_42", output_data, 32'd42);
    end
    drive(0, 32'd3, 32'd4, 2'b11, 1'b0, 32'd0); cycle();

    // Wrap-around and shift boundaries
    drive(1, 32'hFFFF_FFFF, 32'd1, 2'b11, 1'b0, 32'd0); cycle();
    check("add_wrap", output_data, 32'd0);
    drive(4, 32'd1, 32'd33, 2'b11, 1'b0, 32'd0); cycle();
    check("shl_33", output_data, 32'd2);
    drive(5, 32'h8000_0000, 32'd31, 2'b11, 1'b0, 32'd0); cycle();
    check("shr_31", output_data, 32'd1);
    drive(3, 32'h1_0000, 32'h1_0000, 2'b11, 1'b0, 32'd0); cycle();
    check("mul_wrap", output_data, 32'd0);
`ifdef ELASTIC_ALU_DIV_EN
    drive(13, 32'd20, 32'd0, 2'b11, 1'b0, 32'd0); cycle();
    check("div_by_0", output_data, 32'hFFFF_FFFF);
    drive(13, 32'd20, 32'd3, 2'b11, 1'b0, 32'd0); cycle();
    check("div_20_3", output_data, 32'd6);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      opc = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom;
      drive(opc, a, b, 2'($urandom_range(0, 3) != 0 ? 3 : $urandom_range(0, 2)),
            ($urandom_range(0, 9) < 3), $urandom);
      cycle();
    end

    // Reset during a stall with a valid token held
    drive(1, 32'd8, 32'd9, 2'b11, 1'b0, 32'd0); cycle();
    drive(1, 32'd1, 32'd1, 2'b11, 1'b1, 32'd0); cycle();
    check("pre_rst_valid", 32'(valid_output), 32'd1);
    drive(10, 32'h50, 32'd5, 2'b11, 1'b1, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_output), 32'd0);
    check("async_rst_data", output_data, 32'd0);
    check("async_rst_switch", 32'(switch_context), 32'd0);
    check("async_rst_mwrite", 32'(memory_write), 32'd0);
    #10;
    check("rst_hold_valid", 32'(valid_output), 32'd0);
    check("rst_hold_switch", 32'(switch_context), 32'd0);
    reset_n = 1'b1;
    m_valid = 1'b0;
    m_data  = 32'd0;
    drive(0, 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    drive(6, 32'hF0F0, 32'h0FF0, 2'b11, 1'b0, 32'd0); cycle();
    check("post_rst_and", output_data, 32'h00F0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_alu.md
Name: elastic_alu

Overview:
- Elastic (SELF-protocol) arithmetic/memory stage inside each CGRA processing element.
- Sits between the operand join (upstream) and the PE output elastic buffer (downstream).
- Consumes one joined operand pair per firing, computes under the current context's opcode and drives one registered result token.
- Pulses switch_context on every firing so the PE advances its configuration index.

Parameters:
DATA_WIDTH, 32, operand/result/memory data width
ADDRESS_WIDTH, 32, memory address width
OPERATION_BIT_LENGTH, 4, opcode width

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
input_data_1  input  DATA_WIDTH  operand A (from join)
input_data_2  input  DATA_WIDTH  operand B (from join)
op  input  OPERATION_BIT_LENGTH  current-context opcode
const_data  input  DATA_WIDTH  current-context constant
valid_input[2]  input  1 each  operand valid (A, B)
stop_input[2]  output  1 each  backpressure to operand sources
output_data  output  DATA_WIDTH  registered result
valid_output  output  1  result token valid
stop_output  input  1  downstream backpressure
memory_read_address  output  ADDRESS_WIDTH  load address
memory_read_data  input  DATA_WIDTH  combinational (same-cycle) read data
memory_write_address  output  ADDRESS_WIDTH  store address
memory_write  output  1  store strobe, sampled by memory at posedge
memory_write_data  output  DATA_WIDTH  store data
switch_context  output  1  one-cycle pulse per firing

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk.
- Reset values: output_data=0, valid_output=0. While reset_n is low, switch_context=0 and memory_write=0.
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB (A-B), 3 MUL (low DATA_WIDTH bits), 4 SHL, 5 SHR (logical).
  - 6 AND, 7 OR, 8 XOR, 9 LOAD, 10 STORE, 11 CONST, 12 ROUTE (result=A).
  - Codes 13-15 behave as NOP, except as noted under Optional Feature.
- Shift amount is the low $clog2(DATA_WIDTH) bits of B.
- All arithmetic is modulo 2^DATA_WIDTH.
- stall = valid_output && stop_output.
- Output token is transferred when valid_output && !stop_output.
- stop_input[0] = stop_input[1] = stall || (op==CONST).
- Firing condition:
  - CONST: fire = !stall. Operands are ignored and not consumed.
  - All other opcodes: fire = valid_input[0] && valid_input[1] && !stall.
- switch_context = fire (combinational). The PE samples it at the same posedge that captures the result.
- On fire with a result-producing op (ADD..XOR, LOAD, CONST, ROUTE, DIV): output_data<=result and valid_output<=1, latency 1 cycle.
- On fire with NOP or STORE: the operand pair is consumed and no token is produced.
  - valid_output<=0 if the current token is leaving this cycle; otherwise it keeps its value.
- With no fire: if valid_output && !stop_output then valid_output<=0; output_data holds.
- A new result may be captured in the same cycle the old token leaves, giving full throughput of 1 token/cycle.
- LOAD: memory_read_address = A[ADDRESS_WIDTH-1:0] (always driven); result = memory_read_data.
- STORE: memory_write = fire; memory_write_address = A; memory_write_data = B.
- Write and read address outputs are combinational from the operands.
- If reset asserts mid-operation, the in-flight token is dropped.
- Opcode changes while stalled do not alter the held output_data.

Optional Feature:
- Macro ELASTIC_ALU_DIV_EN.
- Defined: opcode 13 is unsigned DIV (A/B). B==0 yields all ones.
- Undefined: opcode 13 is NOP and no divider is synthesized.

Decomposition:
- Package elastic_pkg holds:
  - DATA_WIDTH, ADDRESS_WIDTH, OPERATION_BIT_LENGTH defaults.
  - Opcode enum (OP_NOP..OP_DIV).
  - ElasticWire struct {data, valid, stop}.
- One sub-module, elastic_alu_datapath: a purely combinational result function of (op, A, B, const_data, memory_read_data).
- The handshake and output register stay in elastic_alu.

Test Plan:
- ADD: A=5, B=7, both valid, stop_output=0 → after 1 edge output_data=12, valid_output=1; switch_context high exactly during the firing cycle.
- Backpressure: SUB 10-3 fires, then stop_output=1 for 3 cycles → output_data holds 7, stop_input=1, no further switch_context; release → token leaves and the next pair fires in the same cycle.
- LOAD A=0x40, memory returns 0xDEAD → output_data=0xDEAD; STORE A=0x44, B=9 → memory_write=1 for one cycle at address 0x44 with data 9, valid_output stays 0.
- CONST const_data=42 with valid_input=0 → result 42 each free cycle, stop_input=1 throughout; NOP with valid pair → consumed, switch_context=1, no token.
- Wrap/shift: ADD 0xFFFFFFFF+1 → 0; SHL 1 by B=33 → 2; SHR 0x80000000 by 31 → 1; MUL 0x10000*0x10000 → 0.
- Reset asserted mid-stall with valid_output=1 → valid_output=0 and output_data=0 immediately (asynchronously), no switch_context; with ELASTIC_ALU_DIV_EN, DIV 20/0 → 0xFFFFFFFF.
